// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP-slice logic-unit primitives.
// ALU word width, opcode set and operand extension helper.
package dsp_pkg;

  localparam int DSP_ALU_W = 48;

  typedef enum logic [1:0] {
    DSP_AND,
    DSP_OR,
    DSP_XOR,
    DSP_NAND
  } dsp_logic_op_e;

  // Keep only the low w bits of v; callers pass an operand already
  // widened without sign, so the result is a pure zero extension.
  function automatic logic [DSP_ALU_W-1:0] zext48(
    input logic [DSP_ALU_W-1:0] v,
    input int                   w
  );
    logic [DSP_ALU_W-1:0] mask;
    mask = (DSP_ALU_W'(1) << w) - DSP_ALU_W'(1);
    return v & mask;
  endfunction

endpackage

// File: rtl/dsp_logic_unit.sv
// 48-bit combinational logic unit of a DSP slice.
// Opcode selects AND/OR/XOR/NAND of x and z.
module dsp_logic_unit
  import dsp_pkg::*;
(
  input  logic [DSP_ALU_W-1:0] x,
  input  logic [DSP_ALU_W-1:0] z,
  input  dsp_logic_op_e        op,
  output logic [DSP_ALU_W-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      DSP_AND:  result = x & z;
      DSP_OR:   result = x | z;
      DSP_XOR:  result = x ^ z;
      DSP_NAND: result = ~(x & z);
    endcase
  end

endmodule

// File: rtl/dsp_and_i8_core.sv
// DSP-mapped `and i8, i8 -> i8`: zero-extended operands through the
// 48-bit logic unit, with 0, 1 or 2 optional register stages.
module dsp_and_i8_core
  import dsp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  if (WIDTH < 1 || WIDTH > DSP_ALU_W) begin : g_bad_width
    $fatal(1, "dsp_and_i8_core: WIDTH %0d out of 1..48", WIDTH);
  end
  if (LATENCY < 0 || LATENCY > 2) begin : g_bad_latency
    $fatal(1, "dsp_and_i8_core: LATENCY %0d not 0/1/2", LATENCY);
  end

  logic [WIDTH-1:0]     a_s;
  logic [WIDTH-1:0]     b_s;
  logic [DSP_ALU_W-1:0] alu;
  logic [DSP_ALU_W-1:0] a_ext;
  logic [DSP_ALU_W-1:0] b_ext;

  if (LATENCY == 2) begin : g_in_reg
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        a_q <= a;
        b_q <= b;
      end
    end
    assign a_s = a_q;
    assign b_s = b_q;
  end else begin : g_in_comb
    assign a_s = a;
    assign b_s = b;
  end

  assign a_ext = zext48(DSP_ALU_W'(a_s), WIDTH);
  assign b_ext = zext48(DSP_ALU_W'(b_s), WIDTH);

  dsp_logic_unit u_lu (
    .x      (a_ext),
    .z      (b_ext),
    .op     (DSP_AND),
    .result (alu)
  );

  if (LATENCY >= 1) begin : g_out_reg
    logic [WIDTH-1:0] y_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) y_q <= '0;
      else        y_q <= alu[WIDTH-1:0];
    end
    assign y = y_q;
  end else begin : g_out_comb
    assign y = alu[WIDTH-1:0];
  end

  // Upper ALU bits are always zero; clock/reset are idle at LATENCY=0.
  logic unused_sink;
  assign unused_sink = ^{alu, clock, reset};

endmodule

// File: tb/tb_dsp_and_i8_core.sv
// Directed bench for dsp_and_i8_core at LATENCY 0, 1 and 2.
module tb_dsp_and_i8_core;

  logic       clock;
  logic       reset;
  logic [7:0] a0, b0, y0;
  logic [7:0] a1, b1, y1;
  logic [7:0] a2, b2, y2;

  int checks   = 0;
  int failures = 0;

  dsp_and_i8_core #(.WIDTH(8), .LATENCY(0)) u0 (
    .clock (clock), .reset (reset), .a (a0), .b (b0), .y (y0)
  );
  dsp_and_i8_core #(.WIDTH(8), .LATENCY(1)) u1 (
    .clock (clock), .reset (reset), .a (a1), .b (b1), .y (y1)
  );
  dsp_and_i8_core #(.WIDTH(8), .LATENCY(2)) u2 (
    .clock (clock), .reset (reset), .a (a2), .b (b2), .y (y2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [47:0] got,
                       input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a0 = 8'h00; b0 = 8'h00;
    a1 = 8'd67; b1 = 8'd9;
    a2 = 8'h00; b2 = 8'h00;
    #1 reset = 1'b0;
    #1;
    check("l1_rst_async", y1, 8'h00);
    check("l2_rst_async", y2, 8'h00);
    repeat (2) tick();
    check("l1_rst_hold", y1, 8'h00);
    check("l2_rst_hold", y2, 8'h00);

    a0 = 8'd67; b0 = 8'd9; #1;
    check("l0_67_9_in_rst", y0, 8'd1);
    a0 = 8'hFF; b0 = 8'hA5; #1;
    check("l0_ff_a5", y0, 8'hA5);
    a0 = 8'h00; b0 = 8'hFF; #1;
    check("l0_00_ff", y0, 8'h00);
    a0 = 8'h80; b0 = 8'h80; #1;
    check("l0_80_80", y0, 8'h80);
    check("l0_alu_zext", u0.alu, 48'h80);
    a0 = 8'h5A; b0 = 8'h3C; #1;
    check("l0_5a_3c", y0, 8'h18);

    tick();
    reset = 1'b1;
    #1;
    check("l1_pre_edge", y1, 8'h00);
    tick();
    check("l1_first_edge", y1, 8'd1);

    a2 = 8'hF0; b2 = 8'h3C;
    tick();
    check("l2_edge_n1", y2, 8'h00);
    a2 = 8'h0F; b2 = 8'hFF;
    tick();
    check("l2_edge_n2", y2, 8'h30);
    tick();
    check("l2_edge_n3", y2, 8'h0F);

    a2 = 8'hAA; b2 = 8'hCC;
    tick();
    check("l2_inflight", y2, 8'h0F);
    #2 reset = 1'b0;
    #1;
    check("l2_rst_mid", y2, 8'h00);
    check("l1_rst_mid", y1, 8'h00);
    #2 reset = 1'b1;
    tick();
    check("l2_rel_edge1", y2, 8'h00);
    tick();
    check("l2_rel_edge2", y2, 8'h88);
    check("l1_after_rel", y1, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
